// File: rtl/multiplier.sv
// multiplier: sequential 8x8 unsigned shift-and-add multiplier with binary-to-BCD product output
module multiplier (
   input  logic        clk_10kHz,
   input  logic        clrn,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic        load_a,
   input  logic        load_b,
   output logic [15:0] p,
   output logic        done,
   output logic [19:0] p_BCD,
   output logic [1:0]  state,
   output logic [15:0] a_lshift_r,
   output logic [7:0]  b_rshift_r,
   output logic [15:0] sum,
   output logic        z
);
   typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
   state_t      state_q, state_d;
   logic [7:0]  a_q, a_d, b_q, b_d, b_sh_q, b_sh_d;
   logic [15:0] p_q, p_d, a_sh_q, a_sh_d, sum_q, sum_d;
   logic [19:0] bcd;
   assign z          = b_sh_q == 8'd0;
   assign p          = p_q;
   assign done       = state_q == DONE;
   assign state      = state_q;
   assign a_lshift_r = a_sh_q;
   assign b_rshift_r = b_sh_q;
   assign sum        = sum_q;
   assign p_BCD      = bcd;
   always_comb begin
      a_d     = load_a ? a : a_q;
      b_d     = load_b ? b : b_q;
      state_d = state_q;
      p_d     = p_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      if (state_q == IDLE) begin
         if (start) begin
            a_sh_d  = {8'b0, a_q};
            b_sh_d  = b_q;
            sum_d   = 16'd0;
            state_d = CALC;
         end
      end else if (state_q == CALC) begin
         if (z) begin
            p_d     = sum_q;
            state_d = DONE;
         end else begin
            sum_d  = b_sh_q[0] ? sum_q + a_sh_q : sum_q;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
         end
      end else if (state_q == DONE) begin
         state_d = start ? DONE : IDLE;
      end else begin
         state_d = IDLE;
      end
   end
   // double dabble: add 3 to any digit >= 5 before each shift
   always_comb begin
      bcd = 20'd0;
      for (int i = 15; i >= 0; i--) begin
         for (int j = 0; j < 5; j++)
            bcd[4*j +: 4] = bcd[4*j +: 4] > 4'd4 ? bcd[4*j +: 4] + 4'd3 : bcd[4*j +: 4];
         bcd = {bcd[18:0], p_q[i]};
      end
   end
   always_ff @(posedge clk_10kHz or posedge clrn) begin
      if (clrn) begin
         state_q <= IDLE;
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         p_q     <= 16'd0;
         a_sh_q  <= 16'd0;
         b_sh_q  <= 8'd0;
         sum_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
      end
   end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: vector table, random operands and corner sequences checked against an arithmetic model
module tb_multiplier;
   logic        clk_10kHz = 0, clrn = 0, start = 0, load_a = 0, load_b = 0;
   logic [7:0]  a = 0, b = 0;
   logic [15:0] p, a_lshift_r, sum;
   logic [19:0] p_BCD;
   logic [7:0]  b_rshift_r;
   logic [1:0]  state;
   logic        done, z;
   int          tests = 0, fails = 0;

   multiplier dut (.clk_10kHz(clk_10kHz), .clrn(clrn), .start(start), .a(a), .b(b),
      .load_a(load_a), .load_b(load_b), .p(p), .done(done), .p_BCD(p_BCD), .state(state),
      .a_lshift_r(a_lshift_r), .b_rshift_r(b_rshift_r), .sum(sum), .z(z));

   always #5 clk_10kHz = ~clk_10kHz;

   typedef struct { logic [7:0] a; logic [7:0] b; int p; } vec_t;
   vec_t vecs [8];

   function automatic int model_edges(input int bv);
      int k = -1;
      for (int i = 0; i < 8; i++) if ((bv >> i) & 1) k = i;
      return bv == 0 ? 1 : k + 2;
   endfunction

   function automatic logic [19:0] model_bcd(input int v);
      logic [19:0] r = 0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_10kHz);
      #1;
   endtask

   task automatic load(input logic [7:0] av, input logic [7:0] bv);
      a = av; b = bv; load_a = 1; load_b = 1;
      tick();
      load_a = 0; load_b = 0; a = 0; b = 0;
   endtask

   task automatic wait_calc(output int n);
      n = 0;
      while (state == 2'b01 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic run(input logic [7:0] av, input logic [7:0] bv, input int exp_p);
      int n;
      load(av, bv);
      start = 1;
      tick();
      start = 0;
      chk("start_state", state, 1);
      chk("start_a_sh", a_lshift_r, av);
      chk("start_b_sh", b_rshift_r, bv);
      chk("start_sum", sum, 0);
      wait_calc(n);
      chk("calc_edges", n, model_edges(bv));
      chk("done_state", state, 2);
      chk("done_flag", done, 1);
      chk("product", p, exp_p);
      chk("product_bcd", p_BCD, model_bcd(exp_p));
      tick();
      chk("back_idle", state, 0);
      chk("p_hold", p, exp_p);
      chk("done_low", done, 0);
   endtask

   initial begin
      int n, ra, rb;
      vecs[0] = '{8'd62, 8'd3, 186};
      vecs[1] = '{8'd125, 8'd0, 0};
      vecs[2] = '{8'd255, 8'd255, 65025};
      vecs[3] = '{8'd1, 8'd1, 1};
      vecs[4] = '{8'd0, 8'd200, 0};
      vecs[5] = '{8'd128, 8'd128, 16384};
      vecs[6] = '{8'd17, 8'd13, 221};
      vecs[7] = '{8'd255, 8'd1, 255};

      #2 clrn = 1;
      #10 clrn = 0;
      tick();
      chk("rst_state", state, 0);
      chk("rst_p", p, 0);
      chk("rst_done", done, 0);
      chk("rst_z", z, 1);
      chk("rst_bcd", p_BCD, 0);
      chk("rst_sum", sum, 0);

      load(8'd62, 8'd3);
      start = 1;
      tick();
      start = 0;
      chk("s62_a", a_lshift_r, 62);
      chk("s62_b", b_rshift_r, 3);
      tick();
      chk("s62_sum1", sum, 62);
      chk("s62_z1", z, 0);
      tick();
      chk("s62_sum2", sum, 186);
      chk("s62_z2", z, 1);
      chk("s62_state2", state, 1);
      tick();
      chk("s62_done", done, 1);
      chk("s62_p", p, 186);
      chk("s62_bcd", p_BCD, 20'h00186);
      tick();
      chk("s62_idle", state, 0);
      chk("s62_hold", p, 186);

      foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].p);
      chk("max_bcd_const", p_BCD, 20'h00255);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom_range(0, 255);
         rb = $urandom_range(0, 255);
         run(8'(ra), 8'(rb), ra * rb);
      end

      load(8'd200, 8'd200);
      start = 1;
      tick();
      start = 0;
      tick(); tick(); tick();
      clrn = 1;
      #1;
      chk("mid_rst_state", state, 0);
      chk("mid_rst_p", p, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_a_sh", a_lshift_r, 0);
      chk("mid_rst_b_sh", b_rshift_r, 0);
      chk("mid_rst_z", z, 1);
      chk("mid_rst_done", done, 0);
      #2 clrn = 0;
      tick();

      load(8'd10, 8'd200);
      start = 1;
      tick();
      start = 0;
      tick(); tick();
      a = 8'd7; b = 8'd3; load_a = 1; load_b = 1;
      tick();
      load_a = 0; load_b = 0; a = 0; b = 0;
      wait_calc(n);
      chk("busy_load_p", p, 2000);
      tick();
      start = 1;
      tick();
      start = 0;
      wait_calc(n);
      chk("busy_load_next", p, 21);

      load(8'd5, 8'd6);
      start = 1;
      tick();
      wait_calc(n);
      chk("held_done", state, 2);
      tick(); tick(); tick();
      chk("held_stay", state, 2);
      chk("held_flag", done, 1);
      chk("held_p", p, 30);
      start = 0;
      tick();
      chk("held_release", state, 0);
      tick();
      chk("held_idle", state, 0);
      start = 1;
      tick();
      start = 0;
      chk("held_restart", state, 1);
      wait_calc(n);
      chk("held_restart_p", p, 30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier producing a 16-bit product and its 5-digit BCD equivalent.
- Operands are captured into internal registers by separate load strobes. A start pulse runs the iterative multiply.
- Internal datapath registers and the FSM state are exported for display and debug on a slow (10 kHz) board clock.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit product, 20-bit BCD.

Ports:
- clk_10kHz  input  1  system clock; all registers update on the rising edge
- clrn  input  1  asynchronous, active-high reset (high = reset)
- start  input  1  level-sampled start request; acted on only in IDLE
- a  input  8  multiplicand data bus
- b  input  8  multiplier data bus
- load_a  input  1  when high at a clock edge, operand register A <= a
- load_b  input  1  when high at a clock edge, operand register B <= b
- p  output  16  registered product; holds the last result
- done  output  1  high while FSM is in DONE
- p_BCD  output  20  combinational BCD of p; five 4-bit digits, ten-thousands digit in [19:16]
- state  output  2  current FSM state code
- a_lshift_r  output  16  shifting multiplicand register
- b_rshift_r  output  8  shifting multiplier register
- sum  output  16  partial-product accumulator
- z  output  1  combinational; 1 when b_rshift_r == 0

Behaviour:
- Reset (clrn=1, asynchronous): all of the following go to 0: A, B, p, done, a_lshift_r, b_rshift_r, sum. State goes to IDLE. Consequently p_BCD=0 and z=1.
- Operand registers:
  - A and B are 8-bit internal registers.
  - load_a and load_b operate in every state and may be asserted together.
  - Loading mid-computation does not disturb the running multiply; the new values take effect at the next start.
- State encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10. Code 2'b11 is illegal and goes to IDLE on the next edge.
- IDLE:
  - done=0.
  - If start=1 at an edge: a_lshift_r <= {8'b0,A}; b_rshift_r <= B; sum <= 0; next state CALC.
  - p retains its previous value.
- CALC, per edge:
  - If z=1: p <= sum; next state DONE.
  - Otherwise:
    - if b_rshift_r[0]=1, sum <= sum + a_lshift_r (16-bit add, cannot overflow for 8x8 operands);
    - a_lshift_r <= a_lshift_r << 1;
    - b_rshift_r <= b_rshift_r >> 1.
  - start is ignored while in CALC.
- DONE:
  - done=1 and p holds.
  - If start=0, next state IDLE (done drops).
  - If start is still high, remain in DONE; a new multiply requires start to go low and then high again.
- Latency: for B with highest set bit at index k, the FSM stays in CALC for k+2 edges. B=0 gives one CALC edge, so p=0. Worst case B>=128 gives 9 CALC edges.
- p_BCD: pure combinational binary-to-BCD conversion of p (double-dabble or equivalent), range 0..65535. Maximum product 255*255=65025 maps to 20'h65025.
- Reset asserted mid-operation aborts immediately; all outputs return to their reset values.

Test Plan:
- Reset then idle: pulse clrn high with start=0 -> state=00, p=0, done=0, z=1, p_BCD=20'h00000.
- Load 62 and 3, single-cycle start, a/b buses then driven to 0:
  - after the start edge, state=01, a_lshift_r=62, b_rshift_r=3;
  - sum goes 62 then 186, z rises;
  - next edge: state=10, done=1, p=186, p_BCD=20'h00186;
  - returns to IDLE the cycle after start is low, with p still 186.
- Zero multiplier: load A=125, B=0, start -> one CALC edge, then DONE with p=0.
- Maximum: load A=255, B=255, start -> 9 CALC edges, p=65025, p_BCD=20'h65025.
- Reset mid-CALC: A=200, B=200, start, assert clrn after 3 edges -> all outputs 0 and state=IDLE immediately, without waiting for a clock edge.
- Load during CALC: change A via load_a while busy -> current result is unaffected; the next start uses the new A.
- Held start: keep start high through completion -> FSM stays in DONE; no restart until start goes low and then high again.
